ikaopm_timing_gen: RTL and testbench

Master timing generator for the YM2151 core. It divides the phiM clock-enable into the phi1 positive/negative clock-enable pairs that drive every counter and shift-register primitive. It runs the 32-slot operator cycle counter and its slot-31 flag, which is the counter-reset strobe for the BRAM shift registers. It also synchronizes the chip's IC_n (initial clear) pin and stretches it to a guaranteed minimum length before releasing the core.

---
 rtl/ikaopm_timing_gen.sv | 99 +++++++++
 tb/tb_ikaopm_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopm_timing_gen.sv
// Master timing generator: phiM -> phi1 enable pair, 32-slot operator counter,
// and a synchronized, minimum-length internal clear derived from the IC_n pin.
module ikaopm_timing_gen #(
  parameter int IC_MIN = 64
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_PHIM_CEN_n,
  input  logic       i_IC_n,
  output logic       o_phi1,
  output logic       o_phi1_PCEN_n,
  output logic       o_phi1_NCEN_n,
  output logic [4:0] o_SLOT,
  output logic       o_SLOT31,
  output logic       o_IC_n
);

  localparam int CW = (IC_MIN > 1) ? $clog2(IC_MIN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(IC_MIN - 1);

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] clr_cnt, clr_cnt_nxt;
  logic [4:0]    slot_nxt;
  logic          ic_s1, ic_s2;
  logic          pedge, nedge;

  assign pedge = ~o_phi1_PCEN_n;
  assign nedge = ~o_phi1_NCEN_n;

  // phi1 divider: each enable is emitted together with the new phi1 level
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      o_phi1        <= 1'b0;
      o_phi1_PCEN_n <= 1'b1;
      o_phi1_NCEN_n <= 1'b1;
    end else if (!i_PHIM_CEN_n) begin
      o_phi1        <= ~o_phi1;
      o_phi1_PCEN_n <= o_phi1;
      o_phi1_NCEN_n <= ~o_phi1;
    end else begin
      o_phi1_PCEN_n <= 1'b1;
      o_phi1_NCEN_n <= 1'b1;
    end
  end

  // IC_n is asynchronous; resample it only on phi1 falling edges
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      ic_s1 <= 1'b0;
      ic_s2 <= 1'b0;
    end else if (nedge) begin
      ic_s1 <= i_IC_n;
      ic_s2 <= ic_s1;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      o_SLOT  <= 5'd0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      o_SLOT  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    slot_nxt    = o_SLOT;
    case (state)
      ST_RUN: begin
        if (!ic_s2) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
          slot_nxt    = 5'd0;
        end else if (pedge) begin
          slot_nxt = o_SLOT + 5'd1;
        end
      end
      default: begin
        slot_nxt = 5'd0;
        // counter saturates, so a long IC_n low simply waits for ic_s2 to return
        if (pedge) begin
          if (clr_cnt == CNT_MAX && ic_s2) state_nxt = ST_RUN;
          else if (clr_cnt != CNT_MAX)     clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
    endcase
  end

  assign o_IC_n   = (state == ST_RUN);
  assign o_SLOT31 = &o_SLOT;

endmodule

// File: tb/tb_ikaopm_timing_gen.sv
// Randomized bench for ikaopm_timing_gen against an event-level reference model.
module tb_ikaopm_timing_gen;
  localparam int IC_MIN = 64;

  logic       clk = 1'b0;
  logic       rst, phim_n, ic_n;
  logic       phi1, pcen_n, ncen_n, slot31, icout_n;
  logic [4:0] slot;

  int checks = 0, errors = 0;

  // reference model state
  bit m_phi1, m_pcen, m_ncen, m_clear, nh0, nh1;
  int m_slot, m_plen;
  int ecnt;
  bit last_p, last_n, last_en;
  int ph_left = 0, gmin = 4, gmax = 4;

  ikaopm_timing_gen #(.IC_MIN(IC_MIN)) dut (
    .i_EMUCLK(clk), .i_RST(rst), .i_PHIM_CEN_n(phim_n), .i_IC_n(ic_n),
    .o_phi1(phi1), .o_phi1_PCEN_n(pcen_n), .o_phi1_NCEN_n(ncen_n),
    .o_SLOT(slot), .o_SLOT31(slot31), .o_IC_n(icout_n)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dvec();
    return {phi1, pcen_n, ncen_n, slot, slot31, icout_n};
  endfunction

  function automatic logic [9:0] mvec();
    logic [4:0] s;
    s = 5'(m_slot);
    return {m_phi1, m_pcen, m_ncen, s, (m_slot == 31), !m_clear};
  endfunction

  function automatic logic gen_phim();
    if (ph_left == 0) begin
      ph_left = $urandom_range(gmax, gmin) - 1;
      return 1'b0;
    end
    ph_left--;
    return 1'b1;
  endfunction

  // one EMUCLK edge: drive, clock, then advance the model using pre-edge values
  task automatic tick(input logic p, input logic r);
    bit sync, ic_smp;
    phim_n = p;
    rst    = r;
    ic_smp = ic_n;
    @(posedge clk);
    ecnt++;
    last_p  = !m_pcen;
    last_n  = !m_ncen;
    last_en = last_p || last_n;
    sync = nh1;
    if (r) begin
      m_phi1 = 0; m_pcen = 1; m_ncen = 1;
      m_slot = 0; m_clear = 1; m_plen = 0; nh0 = 0; nh1 = 0;
    end else begin
      if (!m_clear && !sync) begin
        m_clear = 1; m_plen = 0; m_slot = 0;
      end else if (m_clear && last_p) begin
        if (m_plen >= IC_MIN - 1 && sync) m_clear = 0;
        else m_plen++;
      end else if (!m_clear && last_p) begin
        m_slot = (m_slot + 1) % 32;
      end
      if (last_n) begin nh1 = nh0; nh0 = ic_smp; end
      if (!p) begin m_pcen = m_phi1; m_ncen = !m_phi1; m_phi1 = !m_phi1; end
      else begin m_pcen = 1; m_ncen = 1; end
    end
    #1;
  endtask

  task automatic step();
    tick(gen_phim(), 1'b0);
  endtask

  task automatic test_reset();
    ic_n = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    checks++;
    if (dvec() !== 10'b0110000000) begin
      errors++; $display("FAIL reset_state got %b exp %b", dvec(), 10'b0110000000);
    end
    checks++;
    if (dvec() !== mvec()) begin errors++; $display("FAIL reset_model got %b exp %b", dvec(), mvec()); end
  endtask

  task automatic test_divider();
    int last_rise = -1, nper = 0;
    bit prev = 0;
    gmin = 4; gmax = 4; ph_left = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      checks++;
      if (dvec() !== mvec()) begin errors++; $display("FAIL div_model cyc %0d got %b exp %b", i, dvec(), mvec()); end
      checks++;
      if (!pcen_n && !ncen_n) begin errors++; $display("FAIL div_both_low cyc %0d got 00 exp not 00", i); end
      if (phi1 && !prev) begin
        if (last_rise >= 0) begin
          checks++;
          if (ecnt - last_rise != 8) begin
            errors++; $display("FAIL div_period got %0d exp 8", ecnt - last_rise);
          end
          nper++;
        end
        last_rise = ecnt;
      end
      prev = phi1;
    end
    checks++;
    if (nper < 15) begin errors++; $display("FAIL div_period_count got %0d exp >=15", nper); end
  endtask

  task automatic test_release();
    int pc = 0, k = 1;
    bit done = 0;
    gmin = 2; gmax = 5; ph_left = 0; ic_n = 1'b1;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3000 && !done; i++) begin
      step();
      if (last_p) pc++;
      checks++;
      if (dvec() !== mvec()) begin errors++; $display("FAIL rel_model got %b exp %b", dvec(), mvec()); end
      if (icout_n) done = 1;
    end
    checks++;
    if (!done || pc != IC_MIN) begin errors++; $display("FAIL rel_pedges got %0d exp %0d", pc, IC_MIN); end
    for (int i = 0; i < 3000 && k <= 33; i++) begin
      step();
      if (last_p) begin
        checks++;
        if (slot !== 5'(k % 32) || slot31 !== (k % 32 == 31)) begin
          errors++; $display("FAIL rel_slot got %0d/%0b exp %0d/%0b", slot, slot31, k % 32, (k % 32 == 31));
        end
        k++;
      end
    end
    checks++;
    if (k <= 33) begin errors++; $display("FAIL rel_slot_timeout got %0d exp 34", k); end
  endtask

  task automatic test_ic_pulse();
    int nn = 0, n2 = -1, ef = -1, en = 0, pc = 0;
    bit found = 0, rel = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      if (last_p && m_slot == 17) found = 1;
    end
    checks++;
    if (slot !== 5'd17) begin errors++; $display("FAIL pulse_slot17 got %0d exp 17", slot); end
    ic_n = 1'b0;
    for (int i = 0; i < 500 && ef < 0; i++) begin
      step();
      if (last_en) en++;
      if (en == 2) ic_n = 1'b1;
      if (last_n) begin nn++; if (nn == 2) n2 = ecnt; end
      if (!icout_n) ef = ecnt;
    end
    checks++;
    if (ef < 0 || ef != n2 + 1) begin errors++; $display("FAIL pulse_latency got %0d exp %0d", ef, n2 + 1); end
    checks++;
    if (slot !== 5'd0) begin errors++; $display("FAIL pulse_slot0 got %0d exp 0", slot); end
    for (int i = 0; i < 3000 && !rel; i++) begin
      step();
      if (last_p) pc++;
      checks++;
      if (dvec() !== mvec()) begin errors++; $display("FAIL pulse_model got %b exp %b", dvec(), mvec()); end
      if (icout_n) rel = 1;
    end
    checks++;
    if (!rel || pc != IC_MIN) begin errors++; $display("FAIL pulse_release got %0d exp %0d", pc, IC_MIN); end
  endtask

  task automatic test_long_hold();
    int en = 0, nn = 0, n2 = -1, pn = -1, er = -1;
    ic_n = 1'b0;
    for (int i = 0; i < 3000 && en < 200; i++) begin
      step();
      if (last_en) en++;
      checks++;
      if (dvec() !== mvec()) begin errors++; $display("FAIL hold_model got %b exp %b", dvec(), mvec()); end
    end
    checks++;
    if (icout_n !== 1'b0) begin errors++; $display("FAIL hold_low got %b exp 0", icout_n); end
    ic_n = 1'b1;
    for (int i = 0; i < 500 && er < 0; i++) begin
      step();
      if (last_p && n2 >= 0 && pn < 0) pn = ecnt;
      if (last_n) begin nn++; if (nn == 2) n2 = ecnt; end
      if (icout_n) er = ecnt;
    end
    checks++;
    if (er < 0 || er != pn) begin errors++; $display("FAIL hold_release got %0d exp %0d", er, pn); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 50 && !m_phi1; i++) step();
    checks++;
    if (phi1 !== 1'b1) begin errors++; $display("FAIL rmid_phi1 got %b exp 1", phi1); end
    tick(1'b0, 1'b1);
    checks++;
    if (dvec() !== 10'b0110000000) begin
      errors++; $display("FAIL rmid_state got %b exp %b", dvec(), 10'b0110000000);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] s_prev2 = 5'd0, s_prev1 = 5'd0;
    bit prevp = 0;
    gmin = 1; gmax = 1; ph_left = 0; ic_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      checks++;
      if (dvec() !== mvec()) begin errors++; $display("FAIL b2b_model got %b exp %b", dvec(), mvec()); end
      if (i > 0) begin
        checks++;
        if ((pcen_n ^ ncen_n) !== 1'b1 || pcen_n === prevp) begin
          errors++; $display("FAIL b2b_alternate got %b%b exp toggled", pcen_n, ncen_n);
        end
      end
      if (i > 200) begin
        checks++;
        if (slot !== s_prev2 + 5'd1) begin errors++; $display("FAIL b2b_slot got %0d exp %0d", slot, s_prev2 + 5'd1); end
      end
      prevp = pcen_n; s_prev2 = s_prev1; s_prev1 = slot;
    end
  endtask

  initial begin
    rst = 1'b1; phim_n = 1'b1; ic_n = 1'b1; ecnt = 0;
    test_reset();
    test_divider();
    test_release();
    test_ic_pulse();
    test_long_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
